dmux_1byn_hs: RTL and testbench
===============================

# dmux_1byn_hs

Registered, parametrised 1-to-N demultiplexer with per-channel valid/ready handshake. It generalises the combinational 1:2 DMUX to N output channels of W-bit data. Each channel has a one-entry output register, and there is an optional broadcast mode. It sits between a single producer and N independent consumers that may stall.

## Interface
- N, default 4: number of output channels; 2 to 16.
- W, default 8: data width in bits.
- SEL_W, default $clog2(N) (minimum 1): select width; derived, never overridden.
- DCNT_W, default 8: width of the drop counter.

- clk, input, 1: single clock; all state changes on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: producer has a word.
- in_ready, output, 1: block accepts the word this cycle (combinational).
- in_data, input, W: data word.
- in_sel, input, SEL_W: destination channel index.
- in_bcast, input, 1: when 1, the word goes to all N channels and in_sel is ignored.
- out_valid, output, N: bit k set means channel k holds a word.
- out_ready, input, N: consumer k takes the word this cycle.
- out_data, output, N*W: channel k data occupies bits [k*W +: W].
- drop_cnt, output, DCNT_W: count of dropped (out-of-range) words; saturating.

## Operation
- Each channel k has a holding register data_k and a flag out_valid[k].
- Transfer in: occurs when in_valid && in_ready.
- Transfer out on channel k: occurs when out_valid[k] && out_ready[k].
- Channel k is free when !out_valid[k] || out_ready[k], so drain and refill can happen in the same cycle.
- in_ready depends on the mode:
  - Unicast, in_sel < N: in_ready = free(in_sel).
  - Unicast, in_sel >= N (only possible when N is not a power of 2): in_ready = 1. The word is dropped and drop_cnt increments, saturating at 2^DCNT_W-1.
  - Broadcast: in_ready = AND over all channels of free(k). The word is loaded into every channel, and all out_valid bits are set on the same edge.
- On transfer in to channel k: data_k <= in_data and out_valid[k] <= 1.
- If channel k drains without a refill, out_valid[k] <= 0 and data_k is held. out_data is don't-care when invalid, but the bench expects it held.
- Channels not addressed keep their state. A stall on one channel never blocks unicast traffic to another channel.
- in_ready must not depend on in_valid.
- in_data, in_sel and in_bcast are sampled only on a transfer-in edge.
- out_ready is ignored for channels whose out_valid is 0.

## Timing
- Reset (asynchronous assert, deassert synchronous to clk by the surrounding design):
  - out_valid = 0 and out_data = 0 on all channels.
  - drop_cnt = 0.
  - in_ready reflects the empty state right after reset: 1 in every mode.
- Latency: a word accepted at edge T is visible at out_valid/out_data immediately after edge T, i.e. one cycle of register latency.
- Throughput: one word per cycle, provided the target consumer keeps out_ready high.
- Full channel with out_ready=0 holds its word indefinitely. in_ready=0 for unicast to that channel and for broadcast.
- Simultaneous drain and refill on the same channel: out_valid stays 1 and data updates to the new word, with no bubble.
- Broadcast while any channel is full and not draining: in_ready=0 and nothing is written to any channel. This is all-or-nothing.
- Reset asserted mid-operation: held words are discarded immediately and drop_cnt clears. No partial state survives.
- drop_cnt saturates and does not wrap.

## Test plan
- Reset, N=4, W=8: assert rst mid-stream with channels 1 and 3 full -> out_valid=4'b0000, out_data=0 and drop_cnt=0 asynchronously, before the next clk edge.
- Unicast routing, out_ready=4'b1111: send 0xA1, 0xB2, 0xC3, 0xD4 with in_sel=0,1,2,3 on consecutive cycles -> each appears one cycle later on its channel only, and in_ready stays 1 throughout.
- Backpressure: out_ready[2]=0, send 0x55 then 0x66 to channel 2 -> 0x55 held; in_ready=0 for in_sel=2 while in_sel=0 traffic still passes. Raise out_ready[2] -> 0x66 loads on the same edge 0x55 drains, and out_valid[2] stays 1.
- Broadcast: channel 1 full and stalled, in_bcast=1 with 0x3C -> in_ready=0 and no channel changes. Release channel 1 -> all four channels show 0x3C with out_valid=4'b1111.
- Drop, N=3, DCNT_W=2: send 5 words with in_sel=3 -> each accepted (in_ready=1), no out_valid set, and drop_cnt reads 1, 2, 3, 3, 3.
- Parameter sweep: N=2, W=1 -> behaves as a registered 1:2 DMUX. in_sel=0 with in_data=1 gives out_valid=2'b01 and out_data=2'b01; in_sel=1 gives out_valid=2'b10 and out_data=2'b10.

Source files
------------

// File: rtl/dmux_1byn_hs_if.sv
// Bus bundle for dmux_1byn_hs: one producer-side handshake in and N consumer-side handshakes out.
// Handshake rule on every port: a word moves on a rising clk edge when valid && ready; valid is
// held with stable payload until it moves, and ready never looks at valid.
interface dmux_1byn_hs_if #(
    parameter int N      = 4,
    parameter int W      = 8,
    parameter int DCNT_W = 8
);
    localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      in_data;
    logic [SEL_W-1:0]  in_sel;
    logic              in_bcast;
    logic [N-1:0]      out_valid;
    logic [N-1:0]      out_ready;
    logic [N*W-1:0]    out_data;
    logic [DCNT_W-1:0] drop_cnt;

    modport master (
        output in_valid, in_data, in_sel, in_bcast, out_ready,
        input  in_ready, out_valid, out_data, drop_cnt
    );

    modport slave (
        input  in_valid, in_data, in_sel, in_bcast, out_ready,
        output in_ready, out_valid, out_data, drop_cnt
    );
endinterface

// File: rtl/dmux_1byn_hs.sv
// Registered 1-to-N demultiplexer with a one-entry holding register per output channel,
// optional all-or-nothing broadcast, and a saturating counter of words sent to nonexistent channels.
module dmux_1byn_hs #(
    parameter int N      = 4,
    parameter int W      = 8,
    parameter int DCNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    dmux_1byn_hs_if.slave    bus
);
    localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]      valid_q;
    logic [N*W-1:0]    data_q;
    logic [DCNT_W-1:0] drop_q;

    logic [N-1:0] free;
    logic [N-1:0] load;
    logic         sel_ok;
    logic         in_ready_c;
    logic         xfer_in;
    logic         drop_inc;

    // A channel can take a new word if it is empty or is being emptied this same cycle.
    assign free     = ~valid_q | bus.out_ready;
    assign sel_ok   = (32'(bus.in_sel) < N);
    assign xfer_in  = bus.in_valid && in_ready_c;
    assign drop_inc = xfer_in && !bus.in_bcast && !sel_ok;

    always_comb begin
        in_ready_c = 1'b1;
        if (bus.in_bcast) begin
            in_ready_c = &free;
        end else if (sel_ok) begin
            in_ready_c = free[bus.in_sel];
        end
    end

    always_comb begin
        load = '0;
        for (int k = 0; k < N; k++) begin
            if (xfer_in && (bus.in_bcast || (sel_ok && bus.in_sel == SEL_W'(k)))) begin
                load[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            data_q  <= '0;
            drop_q  <= '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (load[k]) begin
                    valid_q[k]         <= 1'b1;
                    data_q[k*W +: W]   <= bus.in_data;
                end else if (bus.out_ready[k]) begin
                    valid_q[k]         <= 1'b0;
                end
            end
            if (drop_inc && drop_q != '1) begin
                drop_q <= drop_q + DCNT_W'(1);
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.drop_cnt  = drop_q;
endmodule

// File: tb/tb_dmux_1byn_hs.sv
// Directed bench for dmux_1byn_hs: three instances (N=4/W=8, N=3/DCNT_W=2, N=2/W=1) share
// one clock and reset and are driven with hand-computed vectors.
module tb_dmux_1byn_hs;
    logic clk;
    logic rst;

    int vectors;
    int miscompares;

    dmux_1byn_hs_if #(.N(4), .W(8), .DCNT_W(8)) a_if ();
    dmux_1byn_hs_if #(.N(3), .W(8), .DCNT_W(2)) b_if ();
    dmux_1byn_hs_if #(.N(2), .W(1), .DCNT_W(8)) c_if ();

    dmux_1byn_hs #(.N(4), .W(8), .DCNT_W(8)) u_a (.clk(clk), .rst(rst), .bus(a_if.slave));
    dmux_1byn_hs #(.N(3), .W(8), .DCNT_W(2)) u_b (.clk(clk), .rst(rst), .bus(b_if.slave));
    dmux_1byn_hs #(.N(2), .W(1), .DCNT_W(8)) u_c (.clk(clk), .rst(rst), .bus(c_if.slave));

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    logic [31:0] exp_a;
    logic [7:0]  uni_vals [4];

    initial begin
        vectors     = 0;
        miscompares = 0;
        uni_vals[0] = 8'hA1; uni_vals[1] = 8'hB2; uni_vals[2] = 8'hC3; uni_vals[3] = 8'hD4;

        a_if.in_valid = 1'b0; a_if.in_data = '0; a_if.in_sel = '0; a_if.in_bcast = 1'b0; a_if.out_ready = '0;
        b_if.in_valid = 1'b0; b_if.in_data = '0; b_if.in_sel = '0; b_if.in_bcast = 1'b0; b_if.out_ready = '0;
        c_if.in_valid = 1'b0; c_if.in_data = '0; c_if.in_sel = '0; c_if.in_bcast = 1'b0; c_if.out_ready = '0;

        rst = 1'b1;
        #3;
        check("rst_valid", 32'(a_if.out_valid), 32'h0);
        check("rst_data", a_if.out_data, 32'h0);
        check("rst_drop", 32'(a_if.drop_cnt), 32'h0);
        check("rst_ready_uni", 32'(a_if.in_ready), 32'h1);
        a_if.in_bcast = 1'b1;
        b_if.in_sel   = 2'd3;
        settle();
        check("rst_ready_bcast", 32'(a_if.in_ready), 32'h1);
        check("rst_ready_oob", 32'(b_if.in_ready), 32'h1);
        a_if.in_bcast = 1'b0;
        b_if.in_sel   = 2'd0;
        #8;
        rst = 1'b0;
        step();
        exp_a = 32'h0;

        // unicast routing, all consumers ready
        a_if.out_ready = 4'b1111;
        a_if.in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_if.in_sel  = 2'(i);
            a_if.in_data = uni_vals[i];
            settle();
            check($sformatf("uni_ready%0d", i), 32'(a_if.in_ready), 32'h1);
            step();
            exp_a[i*8 +: 8] = uni_vals[i];
            check($sformatf("uni_valid%0d", i), 32'(a_if.out_valid), 32'(4'b0001 << i));
            check($sformatf("uni_data%0d", i), a_if.out_data, exp_a);
        end
        a_if.in_valid = 1'b0;
        step();
        check("uni_drained", 32'(a_if.out_valid), 32'h0);
        check("uni_held", a_if.out_data, 32'hD4C3B2A1);

        // backpressure on channel 2
        a_if.out_ready = 4'b1011;
        a_if.in_valid  = 1'b1;
        a_if.in_sel    = 2'd2;
        a_if.in_data   = 8'h55;
        settle();
        check("bp_ready_first", 32'(a_if.in_ready), 32'h1);
        step();
        check("bp_valid_55", 32'(a_if.out_valid), 32'b0100);
        check("bp_data_55", a_if.out_data, 32'hD455B2A1);
        a_if.in_data = 8'h66;
        settle();
        check("bp_ready_stall", 32'(a_if.in_ready), 32'h0);
        step();
        check("bp_hold_valid", 32'(a_if.out_valid), 32'b0100);
        check("bp_hold_data", a_if.out_data, 32'hD455B2A1);
        a_if.in_sel  = 2'd0;
        a_if.in_data = 8'h77;
        settle();
        check("bp_ready_ch0", 32'(a_if.in_ready), 32'h1);
        step();
        check("bp_valid_ch0", 32'(a_if.out_valid), 32'b0101);
        check("bp_data_ch0", a_if.out_data, 32'hD455B277);
        a_if.in_sel  = 2'd2;
        a_if.in_data = 8'h66;
        settle();
        check("bp_ready_still", 32'(a_if.in_ready), 32'h0);
        a_if.out_ready = 4'b1111;
        settle();
        check("bp_ready_release", 32'(a_if.in_ready), 32'h1);
        step();
        check("bp_refill_valid", 32'(a_if.out_valid), 32'b0100);
        check("bp_refill_data", a_if.out_data, 32'hD466B277);
        a_if.in_valid = 1'b0;
        step();
        check("bp_drained", 32'(a_if.out_valid), 32'h0);

        // broadcast is all-or-nothing
        a_if.out_ready = 4'b1101;
        a_if.in_valid  = 1'b1;
        a_if.in_sel    = 2'd1;
        a_if.in_data   = 8'h11;
        step();
        check("bc_prep_valid", 32'(a_if.out_valid), 32'b0010);
        check("bc_prep_data", a_if.out_data, 32'hD4661177);
        a_if.in_bcast = 1'b1;
        a_if.in_data  = 8'h3C;
        settle();
        check("bc_ready_blocked", 32'(a_if.in_ready), 32'h0);
        step();
        check("bc_blocked_valid", 32'(a_if.out_valid), 32'b0010);
        check("bc_blocked_data", a_if.out_data, 32'hD4661177);
        a_if.out_ready = 4'b1111;
        settle();
        check("bc_ready_open", 32'(a_if.in_ready), 32'h1);
        step();
        check("bc_valid_all", 32'(a_if.out_valid), 32'b1111);
        check("bc_data_all", a_if.out_data, 32'h3C3C3C3C);
        a_if.in_valid = 1'b0;
        a_if.in_bcast = 1'b0;
        step();
        check("bc_drained", 32'(a_if.out_valid), 32'h0);

        // out-of-range select on N=3 drops and saturates the 2-bit counter
        b_if.out_ready = 3'b111;
        b_if.in_valid  = 1'b1;
        b_if.in_sel    = 2'd3;
        for (int i = 0; i < 5; i++) begin
            b_if.in_data = 8'(i + 1);
            settle();
            check($sformatf("drop_ready%0d", i), 32'(b_if.in_ready), 32'h1);
            step();
            check($sformatf("drop_valid%0d", i), 32'(b_if.out_valid), 32'h0);
            check($sformatf("drop_cnt%0d", i), 32'(b_if.drop_cnt), (i < 3) ? 32'(i + 1) : 32'd3);
        end
        b_if.in_valid = 1'b0;
        check("drop_data_untouched", 32'(b_if.out_data), 32'h0);

        // N=2, W=1 as a registered 1:2 DMUX
        c_if.out_ready = 2'b11;
        c_if.in_valid  = 1'b1;
        c_if.in_sel    = 1'b0;
        c_if.in_data   = 1'b1;
        step();
        check("dm_valid_s0", 32'(c_if.out_valid), 32'b01);
        check("dm_data_s0", 32'(c_if.out_data), 32'b01);
        c_if.in_data = 1'b0;
        step();
        check("dm_valid_s0z", 32'(c_if.out_valid), 32'b01);
        check("dm_data_s0z", 32'(c_if.out_data), 32'b00);
        c_if.in_sel  = 1'b1;
        c_if.in_data = 1'b1;
        step();
        check("dm_valid_s1", 32'(c_if.out_valid), 32'b10);
        check("dm_data_s1", 32'(c_if.out_data), 32'b10);
        c_if.in_valid = 1'b0;
        step();

        // asynchronous reset with channels 1 and 3 full and stalled
        a_if.out_ready = 4'b0000;
        a_if.in_valid  = 1'b1;
        a_if.in_sel    = 2'd1;
        a_if.in_data   = 8'hAA;
        step();
        a_if.in_sel  = 2'd3;
        a_if.in_data = 8'hBB;
        step();
        a_if.in_valid = 1'b0;
        check("ar_pre_valid", 32'(a_if.out_valid), 32'b1010);
        check("ar_pre_data", a_if.out_data, 32'hBB3CAA3C);
        #2;
        rst = 1'b1;
        #1;
        check("ar_valid", 32'(a_if.out_valid), 32'h0);
        check("ar_data", a_if.out_data, 32'h0);
        check("ar_drop_a", 32'(a_if.drop_cnt), 32'h0);
        check("ar_drop_b", 32'(b_if.drop_cnt), 32'h0);
        check("ar_ready", 32'(a_if.in_ready), 32'h1);
        #1;
        rst = 1'b0;
        step();
        check("ar_after_valid", 32'(a_if.out_valid), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
